regfile_wb_arbiter: RTL and testbench

Write-port arbiter that drives the single register-file write port (write_reg / write_data / RegWrite) of the RISC-V core. It merges the one-cycle ALU writeback stream with a long-latency load/store-unit (LSU) writeback stream. LSU results are buffered in a small FIFO. A 32-entry pending scoreboard lets the issue stage detect RAW hazards on destinations whose long-latency result has not yet been written.

---
 rtl/regfile_wb_arbiter_if.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Purpose: groups the writeback-arbiter signals into one bundle. The "slave"
// modport belongs to the arbiter. The "master" modport belongs to whatever
// drives the result streams: the pipeline, or a testbench.
//
// Signals:
//   alu_valid/alu_rd/alu_data      one-cycle ALU writeback stream
//   lsu_valid/lsu_rd/lsu_data      long-latency LSU writeback stream
//   lsu_ready                      arbiter can take an LSU result this cycle
//   pend_set/pend_rd               long-latency op issued, marks rd pending
//   chk_rs1/chk_rs2                issue-stage sources to test for hazards
//   rs1_busy/rs2_busy              source has an outstanding long-latency write
//   write_reg/write_data/RegWrite  registered register-file write port
//   fifo_count                     LSU buffer occupancy
//
// DEPTH must match the DEPTH of the arbiter instance. It sizes fifo_count.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [31:0]   lsu_data;
  logic          pend_set;
  logic [4:0]    pend_rd;
  logic [4:0]    chk_rs1;
  logic [4:0]    chk_rs2;
  logic          rs1_busy;
  logic          rs2_busy;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic          RegWrite;
  logic [CW-1:0] fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output pend_set, pend_rd, chk_rs1, chk_rs2,
    input  lsu_ready, rs1_busy, rs2_busy,
    input  write_reg, write_data, RegWrite, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  pend_set, pend_rd, chk_rs1, chk_rs2,
    output lsu_ready, rs1_busy, rs2_busy,
    output write_reg, write_data, RegWrite, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose: drives the single register-file write port. Two result streams
// share it:
//   - the ALU stream, which has priority and is always accepted;
//   - the LSU stream, which is buffered in a small circular FIFO and drained
//     whenever the ALU leaves the write port free.
// A 32-bit pending scoreboard marks destinations whose long-latency result
// has not been written yet. The issue stage uses it to detect RAW hazards.
//
// Ports:
//   clk    rising-edge clock
//   rsta   asynchronous active-low reset. It clears the FIFO, the scoreboard
//          and the write port immediately.
//   bus    regfile_wb_arbiter_if.slave. It carries the ALU/LSU streams, the
//          scoreboard set/check ports, the registered write port and the
//          FIFO occupancy.
//
// Parameter:
//   DEPTH  number of LSU FIFO entries. It must be a power of two, at least 2,
//          and equal to the DEPTH of the connected interface.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rsta,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Each FIFO entry is {rd, data}.
  logic [36:0]   mem_q [DEPTH];
  logic [36:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pending_q, pending_d;

  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          reg_write_q, reg_write_d;

  logic          alu_wr;
  logic          fifo_empty;
  logic          lsu_ready;
  logic          lsu_accept;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  // Handshake and arbitration decisions.
  // lsu_ready is taken from the registered count only. A full FIFO therefore
  // refuses a push even in a cycle where it is also popping; this keeps the
  // ready path free of any dependence on the ALU inputs.
  // A write to x0 is never issued. An ALU result for x0 leaves the port free
  // so the FIFO can drain in that cycle. An LSU result for x0 is accepted and
  // dropped instead of taking a FIFO slot.
  always_comb begin
    alu_wr     = bus.alu_valid && (bus.alu_rd != 5'd0);
    fifo_empty = (count_q == '0);
    lsu_ready  = (count_q < CW'(DEPTH));
    lsu_accept = bus.lsu_valid && lsu_ready;
    push       = lsu_accept && (bus.lsu_rd != 5'd0);
    pop        = !alu_wr && !fifo_empty;
    head_rd    = mem_q[rd_ptr_q][36:32];
    head_data  = mem_q[rd_ptr_q][31:0];
  end

  // FIFO storage and pointers.
  // Because DEPTH is a power of two, the pointers wrap naturally modulo
  // DEPTH. The count gets a spare bit so that a full FIFO can be told apart
  // from an empty one.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.lsu_rd, bus.lsu_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pending scoreboard.
  // A pending bit is cleared only when the FIFO entry for that rd reaches the
  // write port. ALU writes leave the bits alone. The set is applied after the
  // clear, so a new long-latency op for the same rd in that cycle keeps it
  // pending.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (bus.pend_set && (bus.pend_rd != 5'd0)) begin
      pending_d[bus.pend_rd] = 1'b1;
    end
  end

  // Write-port selection: the ALU first, then the FIFO head. When neither
  // writes, the address and data keep their last values and only the enable
  // drops.
  always_comb begin
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    if (alu_wr) begin
      write_reg_d  = bus.alu_rd;
      write_data_d = bus.alu_data;
      reg_write_d  = 1'b1;
    end else if (pop) begin
      write_reg_d  = head_rd;
      write_data_d = head_data;
      reg_write_d  = 1'b1;
    end
  end

  // All state, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
    end
  end

  // Outputs. The busy flags are combinational from the registered scoreboard,
  // and x0 is never reported busy.
  assign bus.lsu_ready  = lsu_ready;
  assign bus.fifo_count = count_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.rs1_busy   = pending_q[bus.chk_rs1] && (bus.chk_rs1 != 5'd0);
  assign bus.rs2_busy   = pending_q[bus.chk_rs2] && (bus.chk_rs2 != 5'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Purpose: self-checking bench for regfile_wb_arbiter.
//
// Each table row holds:
//   - one cycle of inputs;
//   - the outputs expected before the next edge (ready, count, busy);
//   - the write expected on the port after that edge.
// The expected write is pushed to a scoreboard queue when the row is driven.
// It is popped and compared one cycle later. A hand-written sequence then
// covers reset asserted mid-operation.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        ps;
    logic [4:0]  prd;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_b1;
    logic        e_b2;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clk;
  logic rsta;
  int   errors;
  int   checks;
  vec_t vecs[$];
  wb_t  sb[$];

  regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rsta (rsta),
    .bus  (bus.slave)
  );

  // 10 ns clock. Inputs change on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the sequence ever stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and record the result.
  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic ps, input logic [4:0] prd,
    input logic [4:0] c1, input logic [4:0] c2,
    input logic rdy, input logic [2:0] cnt, input logic b1, input logic b2,
    input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.ps = ps; v.prd = prd; v.c1 = c1; v.c2 = c2;
    v.e_ready = rdy; v.e_count = cnt; v.e_b1 = b1; v.e_b2 = b2;
    v.e_we = we; v.e_rd = wrd; v.e_data = wdat;
    return v;
  endfunction

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
    bus.pend_set  = 1'b0; bus.pend_rd = 5'd0;
    bus.chk_rs1   = 5'd0; bus.chk_rs2 = 5'd0;
  endtask

  // Drive one row, queue its expected write, and check the outputs that
  // come from the current registered state.
  task automatic applyStimulus(input vec_t v, input int idx);
    wb_t e;
    bus.alu_valid = v.av; bus.alu_rd = v.ard; bus.alu_data = v.adat;
    bus.lsu_valid = v.lv; bus.lsu_rd = v.lrd; bus.lsu_data = v.ldat;
    bus.pend_set  = v.ps; bus.pend_rd = v.prd;
    bus.chk_rs1   = v.c1; bus.chk_rs2 = v.c2;
    e.we = v.e_we; e.rd = v.e_rd; e.data = v.e_data;
    sb.push_back(e);
    #2;
    check_val($sformatf("lsu_ready[%0d]", idx), 32'(bus.lsu_ready), 32'(v.e_ready));
    check_val($sformatf("fifo_count[%0d]", idx), 32'(bus.fifo_count), 32'(v.e_count));
    check_val($sformatf("rs1_busy[%0d]", idx), 32'(bus.rs1_busy), 32'(v.e_b1));
    check_val($sformatf("rs2_busy[%0d]", idx), 32'(bus.rs2_busy), 32'(v.e_b2));
  endtask

  // Pop the oldest expected write and compare it with the write port.
  task automatic checkOutput(input int idx);
    wb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard[%0d]: got empty expected entry", idx);
    end else begin
      e = sb.pop_front();
      check_val($sformatf("RegWrite[%0d]", idx), 32'(bus.RegWrite), 32'(e.we));
      if (e.we) begin
        check_val($sformatf("write_reg[%0d]", idx), 32'(bus.write_reg), 32'(e.rd));
        check_val($sformatf("write_data[%0d]", idx), bus.write_data, e.data);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rsta   = 1'b0;
    drive_idle();

    // Columns: alu(v,rd,data) lsu(v,rd,data) pend(set,rd) chk(rs1,rs2) |
    // pre-edge(ready,count,b1,b2) | next write(we,rd,data).
    // ALU single write, then idle.
    vecs.push_back(mkv(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0, 1,0,0,0, 1,5,32'hDEADBEEF));
    vecs.push_back(mkv(0,0,0,            0,0,0, 0,0, 0,0, 1,0,0,0, 0,0,0));
    // Pending rd7, LSU result for rd7, then busy clears.
    vecs.push_back(mkv(0,0,0, 0,0,0,           1,7, 7,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mkv(0,0,0, 1,7,32'h12345678,0,0, 7,0, 1,0,1,0, 0,0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,           0,0, 7,0, 1,1,1,0, 1,7,32'h12345678));
    vecs.push_back(mkv(0,0,0, 0,0,0,           0,0, 0,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,           0,0, 7,7, 1,0,0,0, 0,0,0));
    // Fill the FIFO under continuous ALU rd9 writes. Full refuses rd5, even
    // while popping. Then drain in order.
    vecs.push_back(mkv(1,9,32'hA0, 1,1,32'h11, 0,0, 0,0, 1,0,0,0, 1,9,32'hA0));
    vecs.push_back(mkv(1,9,32'hA1, 1,2,32'h22, 0,0, 0,0, 1,1,0,0, 1,9,32'hA1));
    vecs.push_back(mkv(1,9,32'hA2, 1,3,32'h33, 0,0, 0,0, 1,2,0,0, 1,9,32'hA2));
    vecs.push_back(mkv(1,9,32'hA3, 1,4,32'h44, 0,0, 0,0, 1,3,0,0, 1,9,32'hA3));
    vecs.push_back(mkv(1,9,32'hA4, 1,5,32'h55, 0,0, 0,0, 0,4,0,0, 1,9,32'hA4));
    vecs.push_back(mkv(0,0,0,      1,5,32'h55, 0,0, 0,0, 0,4,0,0, 1,1,32'h11));
    vecs.push_back(mkv(0,0,0,      0,0,0,      0,0, 0,0, 1,3,0,0, 1,2,32'h22));
    vecs.push_back(mkv(0,0,0,      0,0,0,      0,0, 0,0, 1,2,0,0, 1,3,32'h33));
    vecs.push_back(mkv(0,0,0,      0,0,0,      0,0, 0,0, 1,1,0,0, 1,4,32'h44));
    vecs.push_back(mkv(0,0,0,      0,0,0,      0,0, 0,0, 1,0,0,0, 0,0,0));
    // alu_rd=0 lets rd3 drain. An LSU result for rd0 is dropped.
    vecs.push_back(mkv(0,0,0,            1,3,32'h3333, 0,0, 0,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mkv(1,0,32'hFFFFFFFF, 0,0,0,        0,0, 0,0, 1,1,0,0, 1,3,32'h3333));
    vecs.push_back(mkv(1,0,32'hFFFFFFFF, 1,0,32'hBAD0, 0,0, 0,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mkv(0,0,0,            0,0,0,        0,0, 0,0, 1,0,0,0, 0,0,0));
    // Set and clear of rd6 in the same cycle: the set wins.
    vecs.push_back(mkv(0,0,0, 0,0,0,        1,6, 6,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mkv(0,0,0, 1,6,32'h6666, 0,0, 6,0, 1,0,1,0, 0,0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,        1,6, 0,6, 1,1,0,1, 1,6,32'h6666));
    vecs.push_back(mkv(0,0,0, 0,0,0,        0,0, 6,6, 1,0,1,1, 0,0,0));
    vecs.push_back(mkv(0,0,0, 1,6,32'h7777, 0,0, 6,0, 1,0,1,0, 0,0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,        0,0, 6,0, 1,1,1,0, 1,6,32'h7777));
    vecs.push_back(mkv(0,0,0, 0,0,0,        0,0, 6,6, 1,0,0,0, 0,0,0));
    // Two pending LSU entries held back by ALU traffic, ahead of the reset.
    vecs.push_back(mkv(1,9,32'hC0, 1,10,32'h1010, 1,10, 10,11, 1,0,0,0, 1,9,32'hC0));
    vecs.push_back(mkv(1,9,32'hC1, 1,11,32'h1111, 1,11, 10,11, 1,1,1,0, 1,9,32'hC1));

    // Reset state.
    #1;
    check_val("reset RegWrite", 32'(bus.RegWrite), 32'd0);
    check_val("reset write_reg", 32'(bus.write_reg), 32'd0);
    check_val("reset write_data", bus.write_data, 32'd0);
    check_val("reset fifo_count", 32'(bus.fifo_count), 32'd0);
    check_val("reset lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check_val("reset rs1_busy", 32'(bus.rs1_busy), 32'd0);

    @(negedge clk);
    rsta = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i);
      @(negedge clk);
      checkOutput(i);
    end

    // Reset in mid-operation. Keep the ALU busy so both entries stay queued,
    // then drop rsta between edges.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hC2;
    bus.lsu_valid = 1'b0; bus.pend_set = 1'b0;
    bus.chk_rs1 = 5'd10; bus.chk_rs2 = 5'd11;
    #2;
    check_val("pre-reset fifo_count", 32'(bus.fifo_count), 32'd2);
    check_val("pre-reset rs1_busy", 32'(bus.rs1_busy), 32'd1);
    check_val("pre-reset rs2_busy", 32'(bus.rs2_busy), 32'd1);
    @(posedge clk);
    #3;
    check_val("pre-reset RegWrite", 32'(bus.RegWrite), 32'd1);
    rsta = 1'b0;
    #1;
    check_val("async RegWrite", 32'(bus.RegWrite), 32'd0);
    check_val("async write_reg", 32'(bus.write_reg), 32'd0);
    check_val("async write_data", bus.write_data, 32'd0);
    check_val("async fifo_count", 32'(bus.fifo_count), 32'd0);
    check_val("async lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check_val("async rs1_busy", 32'(bus.rs1_busy), 32'd0);
    check_val("async rs2_busy", 32'(bus.rs2_busy), 32'd0);
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rsta = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val($sformatf("post-reset RegWrite[%0d]", k), 32'(bus.RegWrite), 32'd0);
      check_val($sformatf("post-reset fifo_count[%0d]", k), 32'(bus.fifo_count), 32'd0);
      check_val($sformatf("post-reset rs1_busy[%0d]", k), 32'(bus.rs1_busy), 32'd0);
    end
    check_val("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
